// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared defaults and the count-width helper for pipe_reg_sync.
package pipe_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_sync_if.sv
// pipe_reg_sync_if: producer/consumer handshake bundle of the register pipeline.
//
// Handshake: a word moves across a port on a rising clock edge exactly when
// valid and ready are both high in the cycle before that edge. valid never
// waits for ready. ready may depend combinationally on the other side's ready,
// but never on valid. The master modport is the environment that drives
// in_* and out_ready. The slave modport is the pipeline.
interface pipe_reg_sync_if import pipe_reg_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one valid/data register pair of the pipeline.
// load takes precedence over clear. With neither, the pair holds. A clear drops
// only the valid bit, so the data word stays visible after the stage empties.
module pipe_reg_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             vld_q,
    output logic [WIDTH-1:0] dat_q
);

    logic             vld_d;
    logic [WIDTH-1:0] dat_d;

    // Next-state selection: load a new word, drop validity, or hold.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = d;
        end else if (clear) begin
            vld_d = 1'b0;
        end
    end

    // Stage registers. Reset empties the stage and restores the reset word.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            vld_q <= 1'b0;
            dat_q <= RST_VAL;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/pipe_reg_sync.sv
// pipe_reg_sync: elastic DEPTH-stage register pipeline with valid/ready stall
// support and bubble collapse. Optional feature macro: PIPE_REG_FLUSH_EN adds a
// flush input that empties every stage without touching the data words.
module pipe_reg_sync import pipe_reg_pkg::*; #(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  sync_rst,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                  flush,
`endif
    pipe_reg_sync_if.slave        bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic             flush_i;
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] clear;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

`ifdef PIPE_REG_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Ready chain from the output end back to the input. A stage can take a
    // word when it is empty or its own word is moving on this cycle.
    always_comb begin
        logic chain;
        chain          = !vld[DEPTH-1] || bus.out_ready;
        rdy[DEPTH-1]   = chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain  = !vld[i] || chain;
            rdy[i] = chain;
        end
    end

    assign in_ready = rdy[0] && !sync_rst && !flush_i;
    assign accept   = bus.in_valid && in_ready;
    assign consume  = vld[DEPTH-1] && bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_vld;
        logic [WIDTH-1:0] src_dat;

        if (i == 0) begin : g_head
            assign src_vld = bus.in_valid;
            assign src_dat = bus.in_data;
        end else begin : g_body
            assign src_vld = vld[i-1];
            assign src_dat = dat[i-1];
        end

        // Flush suppresses every load and empties the stage.
        assign load[i]  = rdy[i] && src_vld && !flush_i;
        assign clear[i] = flush_i || (rdy[i] && !src_vld);

        pipe_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .sync_rst (sync_rst),
            .load     (load[i]),
            .clear    (clear[i]),
            .d        (src_dat),
            .vld_q    (vld[i]),
            .dat_q    (dat[i])
        );
    end

    // Occupancy update from the two handshakes. A flush empties the pipeline.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(accept) - CNT_W'(consume);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.out_data  = dat[DEPTH-1];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_reg_sync.sv
// tb_pipe_reg_sync: directed and random stimulus for pipe_reg_sync (WIDTH 8,
// DEPTH 3, reset word A5). The reference keeps in-flight words as a queue with
// a pipeline position for each word. Every cycle each word moves one position
// forward, but it cannot pass the position of the word ahead of it.
module tb_pipe_reg_sync;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 3;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic clk;
    logic sync_rst;
`ifdef PIPE_REG_FLUSH_EN
    logic flush;
`endif

    pipe_reg_sync_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_reg_sync #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
`ifdef PIPE_REG_FLUSH_EN
        .flush    (flush),
`endif
        .bus      (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: words in flight, oldest first, with their positions.
    logic [WIDTH-1:0] exp_q[$];
    int               pos_q[$];
    logic [WIDTH-1:0] last_out;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check the outputs against the reference, then advance
    // the reference across the clock edge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [WIDTH-1:0] d, input logic ordy);
        int  newpos[$];
        int  n;
        int  ahead;
        int  np;
        bit  exp_ov;
        bit  pop;
        bit  exp_rdy;

        @(negedge clk);
        sync_rst      = rst;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
`ifdef PIPE_REG_FLUSH_EN
        flush         = fl;
`endif
        #1;

        n      = pos_q.size();
        exp_ov = (n > 0) && (pos_q[0] == DEPTH - 1);
        pop    = exp_ov && ordy;
        newpos = {};
        ahead  = DEPTH;
        for (int k = (pop ? 1 : 0); k < n; k++) begin
            np = pos_q[k] + 1;
            if (np > ahead - 1) np = ahead - 1;
            newpos.push_back(np);
            ahead = np;
        end
        exp_rdy = !rst && !fl && ((newpos.size() == 0) || (newpos[newpos.size()-1] > 0));

        check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
        check_eq("out_data", {24'd0, bus.out_data}, {24'd0, last_out});
        check_eq("count", {30'd0, bus.count}, n);

        @(posedge clk);
        if (rst) begin
            exp_q    = {};
            pos_q    = {};
            last_out = RST_VAL;
        end else if (fl) begin
            exp_q = {};
            pos_q = {};
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                void'(pos_q.pop_front());
            end
            for (int k = 0; k < pos_q.size(); k++) pos_q[k] = newpos[k];
            if (iv && exp_rdy) begin
                exp_q.push_back(d);
                pos_q.push_back(0);
            end
            for (int k = 0; k < pos_q.size(); k++) begin
                if (pos_q[k] == DEPTH - 1) last_out = exp_q[k];
            end
        end
    endtask

    task automatic idle(input int cycles, input logic ordy);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, 8'h00, ordy);
    endtask

    // Stimulus.
    initial begin
        logic             r_rst;
        logic             r_fl;
        logic             r_iv;
        logic [WIDTH-1:0] r_d;
        logic             r_ordy;

        sync_rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
        flush         = 1'b0;
`endif
        repeat (2) @(posedge clk);
        exp_q    = {};
        pos_q    = {};
        last_out = RST_VAL;

        // Reset values, then release.
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Streaming with the consumer always ready.
        for (int v = 1; v <= 8; v++) step(1'b0, 1'b0, 1'b1, 8'(v), 1'b1);
        idle(4, 1'b1);

        // Backpressure: the fourth word waits until the first pop.
        for (int v = 1; v <= 4; v++) step(1'b0, 1'b0, 1'b1, 8'(v), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
        idle(5, 1'b1);

        // Bubble collapse under stall.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        idle(4, 1'b0);
        idle(3, 1'b1);

        // Reset in the middle of a full, stalled pipeline.
        for (int v = 0; v < 3; v++) step(1'b0, 1'b0, 1'b1, 8'h30 + 8'(v), 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h3F, 1'b1);
        idle(4, 1'b1);

`ifdef PIPE_REG_FLUSH_EN
        // Flush with a word offered at the same time.
        step(1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h42, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h43, 1'b0);
        idle(3, 1'b1);
`endif

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            r_rst  = ($urandom_range(0, 63) == 0);
`ifdef PIPE_REG_FLUSH_EN
            r_fl   = ($urandom_range(0, 39) == 0);
`else
            r_fl   = 1'b0;
`endif
            r_iv   = ($urandom_range(0, 3) != 0);
            r_d    = 8'($urandom);
            r_ordy = ($urandom_range(0, 9) < 6);
            step(r_rst, r_fl, r_iv, r_d, r_ordy);
        end
        idle(5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "time limit reached");
    end

endmodule
